// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin, message-granular arbiter that shares one uart_tx byte input
// between NUM_REQUESTERS byte-stream sources. A requester that wins keeps the
// UART until its tlast byte is accepted, so messages never interleave.
//
// Handshake: every stream uses valid/ready semantics. A byte moves on a
// rising clk edge where valid and ready are both high. A source holds valid,
// data and last stable until that happens. Ready may depend combinationally
// on the owner's valid path, but valid never depends on ready.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to evict an owner that
// has shown no valid byte for TIMEOUT_CYCLES consecutive locked cycles.
// Without the macro, timeout is tied to 0 and a stalled owner blocks forever.
//
// The FSM state is visible on busy (high exactly when the state is LOCKED).

module uart_tx_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int TIMEOUT_CYCLES = 4340
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQUESTERS-1:0]     s_tvalid,
  output logic [NUM_REQUESTERS-1:0]     s_tready,
  input  logic [8*NUM_REQUESTERS-1:0]   s_tdata,
  input  logic [NUM_REQUESTERS-1:0]     s_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [7:0]                    m_tdata,
  output logic [NUM_REQUESTERS-1:0]     grant,
  output logic                          busy,
  output logic                          timeout
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);

  // Reject parameter values outside the supported range at elaboration.
  if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8) begin : g_bad_num_requesters
    $error("uart_tx_arbiter: NUM_REQUESTERS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic [IDX_W-1:0]          sel;
  logic                      found;
  logic                      cur_valid;
  logic                      cur_last;
  logic                      xfer;
  logic                      done;
  logic                      evict;

  // Owner pass-through mux: grant_q is one-hot or zero, so idle selects nothing.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    m_tdata   = 8'h00;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_q[i]) begin
        cur_valid = s_tvalid[i];
        cur_last  = s_tlast[i];
        m_tdata   = s_tdata[8*i +: 8];
      end
    end
  end

  assign m_tvalid = cur_valid;
  assign s_tready = grant_q & {NUM_REQUESTERS{m_tready}};
  assign xfer     = cur_valid & m_tready;
  assign done     = xfer & cur_last;
  assign grant    = grant_q;
  assign busy     = (state_q == LOCKED);

  // Rotating-priority search: first valid index after the last-served one.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand = IDX_W'((int'(last_q) + 1 + k) % NUM_REQUESTERS);
      if (!found && s_tvalid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             timeout_q;

  // Count consecutive locked cycles where the owner offers no byte. A cycle
  // with owner valid (even under m_tready backpressure) restarts the count,
  // and IDLE holds it at zero so every new lock starts fresh.
  always_comb begin
    idle_cnt_d = '0;
    evict      = 1'b0;
    if (state_q == LOCKED && !cur_valid) begin
      if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        evict = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end
  end

  // Idle counter and one-cycle eviction pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= evict;
    end
  end

  assign timeout = timeout_q;
`else
  assign evict   = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, hold the owner in LOCKED until its
  // tlast byte is accepted (or it is evicted).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          grant_d = NUM_REQUESTERS'(1) << sel;
          owner_d = sel;
        end
      end
      LOCKED: begin
        if (done || evict) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQUESTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table-driven per-cycle vectors for the
// arbitration and pass-through behaviour, plus hand-written sequences for
// long backpressure, reset mid-message and owner eviction/stall.

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tready;
  logic [8*N-1:0] s_tdata;
  logic [N-1:0]  s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [7:0]    m_tdata;
  logic [N-1:0]  grant;
  logic          busy;
  logic          timeout;

  uart_tx_arbiter #(
    .NUM_REQUESTERS(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .grant    (grant),
    .busy     (busy),
    .timeout  (timeout)
  );

  // Clock: 10 ns period, active edge is posedge; bench acts on negedge.
  always #5 clk = ~clk;

  typedef struct {
    logic         pre_rst;
    logic [3:0]   valid;
    logic [31:0]  data;
    logic [3:0]   last;
    logic         mready;
    logic         e_mvalid;
    logic [7:0]   e_mdata;
    logic [3:0]   e_sready;
    logic [3:0]   e_grant;
    logic         e_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic r, input logic [3:0] val,
                             input logic [31:0] d, input logic [3:0] l,
                             input logic mr, input logic emv,
                             input logic [7:0] emd, input logic [3:0] esr,
                             input logic [3:0] eg, input logic eb);
    vec_t t;
    t.pre_rst  = r;
    t.valid    = val;
    t.data     = d;
    t.last     = l;
    t.mready   = mr;
    t.e_mvalid = emv;
    t.e_mdata  = emd;
    t.e_sready = esr;
    t.e_grant  = eg;
    t.e_busy   = eb;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic emv,
                           input logic [7:0] emd, input logic [3:0] esr,
                           input logic [3:0] eg, input logic eb);
    check({tag, ".m_tvalid"}, 32'(m_tvalid), 32'(emv));
    check({tag, ".m_tdata"},  32'(m_tdata),  32'(emd));
    check({tag, ".s_tready"}, 32'(s_tready), 32'(esr));
    check({tag, ".grant"},    32'(grant),    32'(eg));
    check({tag, ".busy"},     32'(busy),     32'(eb));
  endtask

  task automatic drive(input logic [3:0] val, input logic [31:0] d,
                       input logic [3:0] l, input logic mr);
    s_tvalid = val;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = mr;
  endtask

  // Reset held across one active edge; returns at a negedge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 32'h0, 4'b0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 32'h0, 4'b0000, 1'b0);

    // Single 3-byte message from requester 2 after reset.
    vecs.push_back(v(1, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0100, 32'h00410000, 4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0100, 32'h00410000, 4'b0000, 1, 1, 8'h41, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0100, 32'h00420000, 4'b0000, 1, 1, 8'h42, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0100, 32'h00430000, 4'b0100, 1, 1, 8'h43, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    // All four valid with 2-byte messages; requester 0 re-requests a 1-byte one.
    vecs.push_back(v(1, 4'b1111, 32'h31211101, 4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b1111, 32'h31211101, 4'b0000, 1, 1, 8'h01, 4'b0001, 4'b0001, 1));
    vecs.push_back(v(0, 4'b1111, 32'h31211102, 4'b0001, 1, 1, 8'h02, 4'b0001, 4'b0001, 1));
    vecs.push_back(v(0, 4'b1111, 32'h31211103, 4'b0001, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b1111, 32'h31211103, 4'b0001, 1, 1, 8'h11, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b1111, 32'h31211203, 4'b0011, 1, 1, 8'h12, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b1101, 32'h31210003, 4'b0001, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b1101, 32'h31210003, 4'b0001, 1, 1, 8'h21, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b1101, 32'h31220003, 4'b0101, 1, 1, 8'h22, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b1001, 32'h31000003, 4'b0001, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b1001, 32'h31000003, 4'b0001, 1, 1, 8'h31, 4'b1000, 4'b1000, 1));
    vecs.push_back(v(0, 4'b1001, 32'h32000003, 4'b1001, 1, 1, 8'h32, 4'b1000, 4'b1000, 1));
    vecs.push_back(v(0, 4'b0001, 32'h00000003, 4'b0001, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0001, 32'h00000003, 4'b0001, 1, 1, 8'h03, 4'b0001, 4'b0001, 1));
    vecs.push_back(v(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    // Requester 1 locked; requester 0 waits, owner stalls by m_tready and by valid.
    vecs.push_back(v(1, 4'b0010, 32'h00005100, 4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0010, 32'h00005100, 4'b0000, 1, 1, 8'h51, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0011, 32'h00005261, 4'b0001, 0, 1, 8'h52, 4'b0000, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0011, 32'h00005261, 4'b0001, 1, 1, 8'h52, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0001, 32'h00000061, 4'b0001, 1, 0, 8'h00, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0011, 32'h00005361, 4'b0011, 1, 1, 8'h53, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0001, 32'h00000061, 4'b0001, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0001, 32'h00000061, 4'b0001, 1, 1, 8'h61, 4'b0001, 4'b0001, 1));
    vecs.push_back(v(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) begin
        do_reset();
        check($sformatf("vec%0d.timeout_after_reset", i), 32'(timeout), 32'h0);
      end
      drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].mready);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_mvalid, vecs[i].e_mdata,
                vecs[i].e_sready, vecs[i].e_grant, vecs[i].e_busy);
      @(negedge clk);
    end

    // Long m_tready backpressure with the owner valid: nothing moves.
    do_reset();
    drive(4'b1000, 32'h77000000, 4'b1000, 1'b0);
    #1;
    check_all("bp.idle", 0, 8'h00, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    for (int c = 0; c < 1000; c++) begin
      check_all($sformatf("bp.c%0d", c), 1, 8'h77, 4'b0000, 4'b1000, 1);
      check($sformatf("bp.c%0d.timeout", c), 32'(timeout), 32'h0);
      @(negedge clk);
    end
    m_tready = 1'b1;
    #1;
    check_all("bp.release", 1, 8'h77, 4'b1000, 4'b1000, 1);
    @(negedge clk);
    check_all("bp.after", 0, 8'h00, 4'b0000, 4'b0000, 0);

    // Reset during byte 2 of requester 1's message, after requester 0 was
    // served, so only reset can give requester 0 priority again.
    do_reset();
    drive(4'b0001, 32'h00000001, 4'b0001, 1'b1);
    @(negedge clk);
    #1;
    check_all("rst.r0", 1, 8'h01, 4'b0001, 4'b0001, 1);
    @(negedge clk);
    drive(4'b0010, 32'h00008100, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
    check_all("rst.b1", 1, 8'h81, 4'b0010, 4'b0010, 1);
    @(negedge clk);
    drive(4'b0010, 32'h00008200, 4'b0000, 1'b1);
    #1;
    check_all("rst.b2", 1, 8'h82, 4'b0010, 4'b0010, 1);
    #1;
    rst = 1'b1;
    #1;
    check_all("rst.async", 0, 8'h00, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1011, 32'h99001105, 4'b1011, 1'b1);
    #1;
    check_all("rst.idle", 0, 8'h00, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    #1;
    check_all("rst.prio0", 1, 8'h05, 4'b0001, 4'b0001, 1);
    @(negedge clk);

    // Owner drops valid after byte 1 while requester 2 waits.
    do_reset();
    drive(4'b0010, 32'h00009100, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
    check_all("to.b1", 1, 8'h91, 4'b0010, 4'b0010, 1);
    @(negedge clk);
    drive(4'b0100, 32'h00a10000, 4'b0100, 1'b1);
    for (int c = 0; c < TO; c++) begin
      #1;
      check($sformatf("to.wait%0d.timeout", c), 32'(timeout), 32'h0);
      check($sformatf("to.wait%0d.grant", c), 32'(grant), 32'h2);
      @(negedge clk);
    end
    #1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    check_all("to.evict", 0, 8'h00, 4'b0000, 4'b0000, 0);
    check("to.evict.timeout", 32'(timeout), 32'h1);
    @(negedge clk);
    #1;
    check_all("to.next", 1, 8'ha1, 4'b0100, 4'b0100, 1);
    check("to.next.timeout", 32'(timeout), 32'h0);
`else
    check_all("to.stall", 0, 8'h00, 4'b0010, 4'b0010, 1);
    check("to.stall.timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    #1;
    check_all("to.stall2", 0, 8'h00, 4'b0010, 4'b0010, 1);
    check("to.stall2.timeout", 32'(timeout), 32'h0);
`endif
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
